iir_seq_ctrl: RTL and testbench
===============================

Name: iir_seq_ctrl

Overview:
Sequencer for the first-order fixed-point IIR section (w0 = x + offset - a*w1; y = b0*w0 + b1*w1). It time-multiplexes one shared fixed-point multiplier and one shared adder across all products and sums of a sample. It owns the coefficient/offset registers and the w1 state register. Samples move in and out over valid/ready handshakes.

Parameters:
N_BITS, 32, data and coefficient word width, signed two's complement
FRAC_BITS, 16, fractional bits (Q(N_BITS-FRAC_BITS).FRAC_BITS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
x_i  in  N_BITS  input sample
x_valid_i  in  1  x_i valid
x_ready_o  out  1  controller can accept a sample
cfg_we_i  in  1  coefficient write strobe
cfg_addr_i  in  2  0=b0, 1=b1, 2=a, 3=offset
cfg_data_i  in  N_BITS  coefficient write data
cfg_err_o  out  1  one-cycle pulse: write rejected (not IDLE)
clear_i  in  1  synchronous: zero w1 and ovf_o (IDLE only)
y_o  out  N_BITS  output sample
y_valid_o  out  1  y_o valid
y_ready_i  in  1  downstream accepts y_o
ovf_o  out  1  sticky: any adder overflow since reset/clear

Behaviour:
- Reset (reset=0, async): state=IDLE; b0, b1, a, offset, w1, x, w0, acc, y_o = 0; x_ready_o=1; y_valid_o=0; cfg_err_o=0; ovf_o=0. Reset mid-sample discards the sample.
- Multiply: full 2*N_BITS signed product, result = product[FRAC_BITS+N_BITS-1:FRAC_BITS] (truncation toward -inf, no saturation).
- Add: N_BITS wrap-around. Overflow occurs when the operand signs are equal and the result sign differs. Overflow sets ovf_o.
- FSM (one multiply and/or one add per state):
  - IDLE: x_ready_o=1. On x_valid_i & x_ready_o: x <= x_i + offset, go to MUL_A.
  - MUL_A: w0 <= x + mul(w1, -a), go to MUL_B0. Negation wraps, so -(0x80000000)=0x80000000.
  - MUL_B0: acc <= mul(w0, b0), go to MUL_B1.
  - MUL_B1: y_o <= acc + mul(w1, b1); w1 <= w0; y_valid_o <= 1, go to OUT.
  - OUT: hold y_o and y_valid_o. On y_ready_i: y_valid_o <= 0, go to IDLE.
- x_ready_o=1 only in IDLE. Latency: acceptance edge E0, y_valid_o high after E3. Minimum interval between samples: 5 cycles (y_ready_i tied high).
- Backpressure: y_ready_i low holds OUT indefinitely. y_o, w1 and coefficients are stable. No input is accepted.
- cfg writes: applied in IDLE on the next edge. In any other state the write is dropped and cfg_err_o pulses for 1 cycle.
  - Write and x handshake on the same IDLE edge: the write takes effect first, so the new offset is used for that sample (same-edge bypass). The new a, b0, b1 are used in later states naturally.
- clear_i in IDLE: w1 <= 0, ovf_o <= 0. Ignored outside IDLE.
  - clear_i with an x handshake on the same edge: clear wins for w1, and the sample proceeds with w1=0.
- ovf_o is sticky, with set priority over clear on the same edge.

Test Plan:
- Passthrough: b0=0x00010000, b1=0, a=0, offset=0, x_i=0x00020000 -> y_o=0x00020000; y_valid_o rises 3 edges after acceptance; ovf_o=0.
- Recursion: b0=0x00010000, a=0x00008000 (0.5), b1=0; three samples x_i=0x00010000 -> y_o=0x00010000, 0x00008000, 0x0000C000.
- Offset + b1: b0=b1=0x00010000, a=0, offset=0x00010000; x_i=0, 0 -> y_o=0x00010000 then 0x00020000.
- Backpressure: hold y_ready_i=0 for 10 cycles -> y_o and y_valid_o stable, x_ready_o=0, second x_valid_i not accepted; release -> IDLE next edge.
- Config guard: write a during MUL_B0 -> cfg_err_o 1-cycle pulse, a unchanged. Write offset=0x00030000 on the same IDLE edge as x_i=0 with b0=1.0 -> y_o=0x00030000.
- Overflow/reset: b0=0x00010000, offset=0x7FFF0000, x_i=0x00020000 -> y_o=0x80010000 (wrapped), ovf_o=1. clear_i in IDLE -> ovf_o=0, w1=0. reset asserted in MUL_B0 -> all outputs 0 and x_ready_o=1 immediately.

Source files
------------

// File: rtl/iir_seq_ctrl.sv
// Sequencer for a first-order fixed-point IIR section: w0 = x + offset - a*w1, y = b0*w0 + b1*w1.
// One shared multiplier and one shared adder are time-multiplexed across the states of a sample.
module iir_seq_ctrl #(
    parameter int unsigned N_BITS    = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] x_i,
    input  logic              x_valid_i,
    output logic              x_ready_o,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_addr_i,
    input  logic [N_BITS-1:0] cfg_data_i,
    output logic              cfg_err_o,
    input  logic              clear_i,
    output logic [N_BITS-1:0] y_o,
    output logic              y_valid_o,
    input  logic              y_ready_i,
    output logic              ovf_o
);

    localparam int unsigned P_BITS = 2 * N_BITS;

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B0, MUL_B1, OUT} state_t;

    state_t            state, state_nxt;
    logic [N_BITS-1:0] b0, b1, a, offset, w1, xs, w0, acc;
    logic [N_BITS-1:0] b0_nxt, b1_nxt, a_nxt, offset_nxt, w1_nxt, xs_nxt, w0_nxt, acc_nxt, y_nxt;
    logic              y_valid_nxt, cfg_err_nxt, ovf_nxt, x_ready_nxt;
    logic              ovf_set, ovf_clr;

    logic [N_BITS-1:0]        mul_a, mul_b, mul_res, neg_a, offset_eff;
    logic signed [P_BITS-1:0] mul_a_ext, mul_b_ext;
    logic [N_BITS-1:0]        add_a, add_b, sum;
    logic                     add_ovf;

    assign neg_a = -a;
    // A same-edge offset write is bypassed into the sample accepted on that edge.
    assign offset_eff = (cfg_we_i && cfg_addr_i == 2'd3) ? cfg_data_i : offset;

    always_comb begin : mul_operand_sel
        mul_a = w1;
        mul_b = neg_a;
        case (state)
            MUL_B0:  begin mul_a = w0; mul_b = b0; end
            MUL_B1:  begin mul_a = w1; mul_b = b1; end
            default: begin mul_a = w1; mul_b = neg_a; end
        endcase
    end

    // Full-width signed product, keep bits [FRAC+N-1:FRAC] (truncation toward -inf).
    assign mul_a_ext = P_BITS'($signed(mul_a));
    assign mul_b_ext = P_BITS'($signed(mul_b));
    assign mul_res   = N_BITS'((mul_a_ext * mul_b_ext) >>> FRAC_BITS);

    always_comb begin : add_operand_sel
        add_a = xs;
        add_b = mul_res;
        case (state)
            IDLE:    begin add_a = x_i; add_b = offset_eff; end
            MUL_B1:  begin add_a = acc; add_b = mul_res;    end
            default: begin add_a = xs;  add_b = mul_res;    end
        endcase
    end

    assign sum     = add_a + add_b;
    assign add_ovf = (add_a[N_BITS-1] == add_b[N_BITS-1]) && (sum[N_BITS-1] != add_a[N_BITS-1]);

    always_comb begin : fsm_next
        state_nxt   = state;
        b0_nxt      = b0;
        b1_nxt      = b1;
        a_nxt       = a;
        offset_nxt  = offset;
        w1_nxt      = w1;
        xs_nxt      = xs;
        w0_nxt      = w0;
        acc_nxt     = acc;
        y_nxt       = y_o;
        y_valid_nxt = y_valid_o;
        cfg_err_nxt = 1'b0;
        ovf_set     = 1'b0;
        ovf_clr     = 1'b0;

        if (state != IDLE) begin
            cfg_err_nxt = cfg_we_i;
        end

        case (state)
            IDLE: begin
                if (cfg_we_i) begin
                    case (cfg_addr_i)
                        2'd0:    b0_nxt     = cfg_data_i;
                        2'd1:    b1_nxt     = cfg_data_i;
                        2'd2:    a_nxt      = cfg_data_i;
                        default: offset_nxt = cfg_data_i;
                    endcase
                end
                if (clear_i) begin
                    w1_nxt  = '0;
                    ovf_clr = 1'b1;
                end
                if (x_valid_i && x_ready_o) begin
                    xs_nxt    = sum;
                    ovf_set   = add_ovf;
                    state_nxt = MUL_A;
                end
            end
            MUL_A: begin
                w0_nxt    = sum;
                ovf_set   = add_ovf;
                state_nxt = MUL_B0;
            end
            MUL_B0: begin
                acc_nxt   = mul_res;
                state_nxt = MUL_B1;
            end
            MUL_B1: begin
                y_nxt       = sum;
                ovf_set     = add_ovf;
                w1_nxt      = w0;
                y_valid_nxt = 1'b1;
                state_nxt   = OUT;
            end
            OUT: begin
                if (y_ready_i) begin
                    y_valid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ovf_nxt     = ovf_set || (ovf_o && !ovf_clr);
        x_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state     <= IDLE;
            b0        <= '0;
            b1        <= '0;
            a         <= '0;
            offset    <= '0;
            w1        <= '0;
            xs        <= '0;
            w0        <= '0;
            acc       <= '0;
            y_o       <= '0;
            y_valid_o <= 1'b0;
            cfg_err_o <= 1'b0;
            ovf_o     <= 1'b0;
            x_ready_o <= 1'b1;
        end else begin
            state     <= state_nxt;
            b0        <= b0_nxt;
            b1        <= b1_nxt;
            a         <= a_nxt;
            offset    <= offset_nxt;
            w1        <= w1_nxt;
            xs        <= xs_nxt;
            w0        <= w0_nxt;
            acc       <= acc_nxt;
            y_o       <= y_nxt;
            y_valid_o <= y_valid_nxt;
            cfg_err_o <= cfg_err_nxt;
            ovf_o     <= ovf_nxt;
            x_ready_o <= x_ready_nxt;
        end
    end

endmodule

// File: tb/tb_iir_seq_ctrl.sv
// Self-checking bench for iir_seq_ctrl: directed scenarios plus randomized samples
// compared against an equation-level fixed-point model of the filter.
module tb_iir_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] x_i;
    logic        x_valid_i;
    logic        x_ready_o;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic        cfg_err_o;
    logic        clear_i;
    logic [31:0] y_o;
    logic        y_valid_o;
    logic        y_ready_i;
    logic        ovf_o;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_b0, m_b1, m_a, m_off, m_w1;
    logic        m_ovf;

    iir_seq_ctrl #(.N_BITS(32), .FRAC_BITS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_i        (x_i),
        .x_valid_i  (x_valid_i),
        .x_ready_o  (x_ready_o),
        .cfg_we_i   (cfg_we_i),
        .cfg_addr_i (cfg_addr_i),
        .cfg_data_i (cfg_data_i),
        .cfg_err_o  (cfg_err_o),
        .clear_i    (clear_i),
        .y_o        (y_o),
        .y_valid_o  (y_valid_o),
        .y_ready_i  (y_ready_i),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Real-valued fixed-point arithmetic on 64-bit integers.
    function automatic logic [31:0] m_mul(input logic [31:0] p, input logic [31:0] q);
        longint prod;
        prod = longint'($signed(p)) * longint'($signed(q));
        return 32'(prod >>> 16);
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] p, input logic [31:0] q);
        longint s;
        s = longint'($signed(p)) + longint'($signed(q));
        if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1'b1;
        return 32'(s);
    endfunction

    function automatic logic [31:0] m_neg(input logic [31:0] p);
        return 32'(-longint'($signed(p)));
    endfunction

    function automatic void m_cfg(input logic [1:0] ad, input logic [31:0] d);
        case (ad)
            2'd0:    m_b0  = d;
            2'd1:    m_b1  = d;
            2'd2:    m_a   = d;
            default: m_off = d;
        endcase
    endfunction

    function automatic logic [31:0] m_sample(input logic [31:0] xv);
        logic [31:0] w0, yv;
        w0   = m_add(m_add(xv, m_off), m_mul(m_w1, m_neg(m_a)));
        yv   = m_add(m_mul(w0, m_b0), m_mul(m_w1, m_b1));
        m_w1 = w0;
        return yv;
    endfunction

    function automatic void m_reset();
        m_b0 = '0; m_b1 = '0; m_a = '0; m_off = '0; m_w1 = '0; m_ovf = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ad, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = ad; cfg_data_i = d;
        tick();
        cfg_we_i = 1'b0;
        m_cfg(ad, d);
        check("cfg_err_idle", 32'(cfg_err_o), 32'd0);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        m_w1 = '0; m_ovf = 1'b0;
        check("clear_ovf", 32'(ovf_o), 32'd0);
    endtask

    // One sample with optional same-edge cfg write / clear and bp cycles of backpressure.
    task automatic send_sample(input logic [31:0] xv, input bit do_cfg, input logic [1:0] ca,
                               input logic [31:0] cd, input bit do_clr, input int bp,
                               output logic [31:0] y_seen);
        int          n;
        logic [31:0] exp_y;
        n = 0;
        while (!x_ready_o && n < 50) begin tick(); n++; end
        check("ready_idle", 32'(x_ready_o), 32'd1);
        x_i = xv; x_valid_i = 1'b1;
        cfg_we_i = do_cfg; cfg_addr_i = ca; cfg_data_i = cd;
        clear_i = do_clr; y_ready_i = (bp == 0);
        if (do_cfg) m_cfg(ca, cd);
        if (do_clr) begin m_w1 = '0; m_ovf = 1'b0; end
        exp_y = m_sample(xv);
        tick();
        x_valid_i = 1'b0; cfg_we_i = 1'b0; clear_i = 1'b0;
        n = 0;
        while (!y_valid_o && n < 20) begin tick(); n++; end
        check("latency", 32'(n), 32'd3);
        check("y", y_o, exp_y);
        check("ovf", 32'(ovf_o), 32'(m_ovf));
        y_seen = y_o;
        if (bp > 0) begin
            x_valid_i = 1'b1; x_i = $urandom;
            for (int i = 0; i < bp; i++) begin
                tick();
                check("bp_y", y_o, exp_y);
                check("bp_valid", 32'(y_valid_o), 32'd1);
                check("bp_ready", 32'(x_ready_o), 32'd0);
            end
            y_ready_i = 1'b1; x_valid_i = 1'b0;
        end
        tick();
        check("back_idle", 32'(x_ready_o), 32'd1);
        check("valid_drop", 32'(y_valid_o), 32'd0);
    endtask

    function automatic logic [31:0] rnd_coef();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] yv;
        logic [31:0] exp_y;
        reset = 1'b0; x_i = '0; x_valid_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0;
        cfg_data_i = '0; clear_i = 1'b0; y_ready_i = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check("rst_y", y_o, 32'd0);
        check("rst_valid", 32'(y_valid_o), 32'd0);
        check("rst_ready", 32'(x_ready_o), 32'd1);
        check("rst_err", 32'(cfg_err_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        tick();

        // Passthrough
        cfg_write(2'd0, 32'h0001_0000);
        send_sample(32'h0002_0000, 1'b0, 2'd0, '0, 1'b0, 0, yv);
        check("pass_y", yv, 32'h0002_0000);

        // Recursion with a = 0.5
        do_clear();
        cfg_write(2'd2, 32'h0000_8000);
        send_sample(32'h0001_0000, 1'b0, 2'd0, '0, 1'b0, 0, yv);
        check("rec_y0", yv, 32'h0001_0000);
        send_sample(32'h0001_0000, 1'b0, 2'd0, '0, 1'b0, 0, yv);
        check("rec_y1", yv, 32'h0000_8000);
        send_sample(32'h0001_0000, 1'b0, 2'd0, '0, 1'b0, 0, yv);
        check("rec_y2", yv, 32'h0000_C000);

        // Offset + b1
        do_clear();
        cfg_write(2'd1, 32'h0001_0000);
        cfg_write(2'd2, 32'h0000_0000);
        cfg_write(2'd3, 32'h0001_0000);
        send_sample(32'h0, 1'b0, 2'd0, '0, 1'b0, 0, yv);
        check("off_y0", yv, 32'h0001_0000);
        send_sample(32'h0, 1'b0, 2'd0, '0, 1'b0, 10, yv);
        check("off_y1_bp", yv, 32'h0002_0000);

        // Config write rejected mid-sample; a stays unchanged
        cfg_write(2'd2, 32'h0000_4000);
        x_i = 32'h0001_0000; x_valid_i = 1'b1;
        exp_y = m_sample(32'h0001_0000);
        tick();
        x_valid_i = 1'b0;
        tick();
        cfg_we_i = 1'b1; cfg_addr_i = 2'd2; cfg_data_i = 32'h1234_5678;
        tick();
        cfg_we_i = 1'b0;
        check("guard_err", 32'(cfg_err_o), 32'd1);
        tick();
        check("guard_err_pulse", 32'(cfg_err_o), 32'd0);
        check("guard_valid", 32'(y_valid_o), 32'd1);
        check("guard_y", y_o, exp_y);
        tick();
        send_sample(32'h0000_2000, 1'b0, 2'd0, '0, 1'b0, 0, yv);

        // Same-edge offset bypass
        do_clear();
        cfg_write(2'd1, 32'h0);
        cfg_write(2'd2, 32'h0);
        send_sample(32'h0, 1'b1, 2'd3, 32'h0003_0000, 1'b0, 0, yv);
        check("bypass_y", yv, 32'h0003_0000);

        // Overflow wraps and is sticky until clear
        cfg_write(2'd3, 32'h7FFF_0000);
        send_sample(32'h0002_0000, 1'b0, 2'd0, '0, 1'b1, 0, yv);
        check("ovf_y", yv, 32'h8001_0000);
        check("ovf_set", 32'(ovf_o), 32'd1);
        do_clear();
        cfg_write(2'd0, 32'h0);
        cfg_write(2'd1, 32'h0001_0000);
        cfg_write(2'd3, 32'h0);
        send_sample(32'h0, 1'b0, 2'd0, '0, 1'b0, 0, yv);
        check("clear_w1", yv, 32'h0);

        // Async reset in MUL_B0
        x_i = 32'h0001_0000; x_valid_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_y", y_o, 32'd0);
        check("mid_rst_ready", 32'(x_ready_o), 32'd1);
        check("mid_rst_valid", 32'(y_valid_o), 32'd0);
        check("mid_rst_ovf", 32'(ovf_o), 32'd0);
        m_reset();
        @(negedge clk) reset = 1'b1;
        tick();

        // Randomized samples
        for (int it = 0; it < 60; it++) begin
            bit          c_same, clr_same;
            logic [1:0]  ca;
            logic [31:0] cd;
            if ($urandom_range(0, 2) == 0) cfg_write(2'($urandom_range(0, 3)), rnd_coef());
            if ($urandom_range(0, 9) == 0) do_clear();
            c_same   = ($urandom_range(0, 3) == 0);
            clr_same = ($urandom_range(0, 7) == 0);
            ca = 2'($urandom_range(0, 3));
            cd = rnd_coef();
            send_sample(($urandom_range(0, 1) == 0) ? $urandom : rnd_coef(),
                        c_same, ca, cd, clr_same, int'($urandom_range(0, 3)), yv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
